serv_bus_responder: RTL and testbench

- Bus target for the SERV core. Answers its instruction fetches (ibus) and data accesses (dbus) from one single-ported RAM.
- Also contains a memory-mapped RISC-V machine timer (mtime/mtimecmp), which drives the core's timer interrupt input.
- Sits beside the CPU at the top of the system. Completes the cyc/ack handshake that the core initiates.

---
 rtl/serv_bus_responder.sv | 174 +++++++++++++++++
 tb/tb_serv_bus_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_bus_responder.sv
// serv_bus_responder: single-port RAM bus target for SERV ibus/dbus with a machine timer on dbus.
// Optional feature: `define SERV_RESP_TIMER_EN enables the mtime/mtimecmp timer and its interrupt.

module serv_bus_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [31:0] TIMER_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic        o_timer_irq
);
    localparam int unsigned MEM_AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        GUARD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ibus_ack_q, ibus_ack_d;
    logic              dbus_ack_q, dbus_ack_d;
    logic [31:0]       ibus_rdt_q, dbus_rdt_q;
    logic              acc_i_c, acc_d_c;
    logic [MEM_AW-1:0] i_idx, d_idx;
    logic              timer_hit, ram_we;
    logic [31:0]       tmr_rdt;
    logic [31:0]       mem_q [MEM_WORDS];
    logic              unused_adr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign i_idx           = i_ibus_adr[MEM_AW+1:2];
    assign d_idx           = i_dbus_adr[MEM_AW+1:2];
    assign timer_hit       = (i_dbus_adr[31:4] == TIMER_BASE[31:4]);
    assign ram_we          = acc_d_c && i_dbus_we && !timer_hit && !i_rst;
    assign unused_adr_bits = ^{i_ibus_adr[31:MEM_AW+2], i_ibus_adr[1:0], i_dbus_adr[1:0]};

    // Handshake FSM: accept in IDLE (dbus has priority), ack in RESP, ignore cyc in GUARD.
    always_comb begin
        state_d    = state_q;
        acc_i_c    = 1'b0;
        acc_d_c    = 1'b0;
        ibus_ack_d = 1'b0;
        dbus_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_dbus_cyc) begin
                    acc_d_c    = 1'b1;
                    dbus_ack_d = 1'b1;
                    state_d    = RESP;
                end else if (i_ibus_cyc) begin
                    acc_i_c    = 1'b1;
                    ibus_ack_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP:    state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ibus_ack_q <= ibus_ack_d;
            dbus_ack_q <= dbus_ack_d;
        end
    end

    // RAM contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_dbus_sel[b]) begin
                    mem_q[d_idx][8*b +: 8] <= i_dbus_dat[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at accept so it shows during RESP and holds afterwards.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            ibus_rdt_q <= 32'h0;
            dbus_rdt_q <= 32'h0;
        end else begin
            if (acc_i_c) begin
                ibus_rdt_q <= mem_q[i_idx];
            end
            if (acc_d_c) begin
                dbus_rdt_q <= i_dbus_we ? 32'h0 : (timer_hit ? tmr_rdt : mem_q[d_idx]);
            end
        end
    end

`ifdef SERV_RESP_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q;
    logic        tmr_we;

    assign tmr_we = acc_d_c && i_dbus_we && timer_hit && !i_rst;

    // A write to an mtime half replaces the increment for that cycle.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (tmr_we) begin
            case (i_dbus_adr[3:2])
                2'd0: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_dbus_dat, i_dbus_sel)};
                2'd1: mtime_d = {merge_bytes(mtime_q[63:32], i_dbus_dat, i_dbus_sel), mtime_q[31:0]};
                2'd2: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], i_dbus_dat, i_dbus_sel);
                default: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], i_dbus_dat, i_dbus_sel);
            endcase
        end
    end

    always_comb begin
        case (i_dbus_adr[3:2])
            2'd0:    tmr_rdt = mtime_q[31:0];
            2'd1:    tmr_rdt = mtime_q[63:32];
            2'd2:    tmr_rdt = mtimecmp_q[31:0];
            default: tmr_rdt = mtimecmp_q[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign o_timer_irq = irq_q;
`else
    assign tmr_rdt     = 32'h0;
    assign o_timer_irq = 1'b0;
`endif

    assign o_ibus_ack = ibus_ack_q;
    assign o_dbus_ack = dbus_ack_q;
    assign o_ibus_rdt = ibus_rdt_q;
    assign o_dbus_rdt = dbus_rdt_q;

endmodule

// File: tb/tb_serv_bus_responder.sv
// Randomized self-checking bench for serv_bus_responder against a timestamp-based reference model.
// Timer expectations follow SERV_RESP_TIMER_EN so the bench suits either build.

module tb_serv_bus_responder;
    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned MEM_AW     = $clog2(MEM_WORDS);
    localparam logic [31:0] TIMER_BASE = 32'h8000_0000;
`ifdef SERV_RESP_TIMER_EN
    localparam bit TMR_EN = 1'b1;
`else
    localparam bit TMR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_ibus_adr = 32'h0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr = 32'h0;
    logic [31:0] i_dbus_dat = 32'h0;
    logic [3:0]  i_dbus_sel = 4'h0;
    logic        i_dbus_we = 1'b0;
    logic        i_dbus_cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic        o_timer_irq;

    serv_bus_responder #(.MEM_WORDS(MEM_WORDS), .TIMER_BASE(TIMER_BASE)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
        .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack), .o_timer_irq(o_timer_irq)
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: RAM image plus timer expressed as (value, cycle it took effect).
    logic [31:0] mem_m [MEM_WORDS];
    bit          valid_m [MEM_WORDS];
    logic [63:0] m_base  = 64'h0;
    int          m_base_cyc = 0;
    logic [63:0] cmp_m   = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mtime_at(input int k);
        if (!TMR_EN) return 64'h0;
        return m_base + 64'(k - m_base_cyc);
    endfunction

    task automatic model_reset();
        m_base     = 64'h0;
        m_base_cyc = cnt;
        cmp_m      = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    // One reset cycle, entered and left just after a rising edge.
    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    // Full dbus transaction starting with the DUT idle; returns DUT read data.
    task automatic dbus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input string tag, output logic [31:0] got);
        int          n, lat, w;
        logic [31:0] exp;
        logic [63:0] m;
        bit          hit;
        n   = cnt;
        hit = (adr[31:4] == TIMER_BASE[31:4]);
        w   = int'(adr[MEM_AW+1:2]);
        exp = 32'h0;
        if (hit) begin
            m = mtime_at(n);
            if (!we && TMR_EN) begin
                case (adr[3:2])
                    2'd0: exp = m[31:0];
                    2'd1: exp = m[63:32];
                    2'd2: exp = cmp_m[31:0];
                    default: exp = cmp_m[63:32];
                endcase
            end
            if (we && TMR_EN) begin
                case (adr[3:2])
                    2'd0: begin m[31:0]  = merge(m[31:0], dat, sel);  m_base = m; m_base_cyc = n + 1; end
                    2'd1: begin m[63:32] = merge(m[63:32], dat, sel); m_base = m; m_base_cyc = n + 1; end
                    2'd2: cmp_m[31:0]  = merge(cmp_m[31:0], dat, sel);
                    default: cmp_m[63:32] = merge(cmp_m[63:32], dat, sel);
                endcase
            end
        end else if (we) begin
            mem_m[w] = merge(mem_m[w], dat, sel);
            valid_m[w] = 1'b1;
        end else begin
            exp = mem_m[w];
        end
        i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel; i_dbus_we = we; i_dbus_cyc = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!o_dbus_ack && lat < 8) begin lat++; @(negedge clk); end
        check_eq({tag, "_lat"}, 64'(lat), 64'd1);
        got = o_dbus_rdt;
        check_eq({tag, "_rdt"}, 64'(got), 64'(exp));
        @(posedge clk); #1;
        i_dbus_cyc = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ack2"}, 64'(o_dbus_ack), 64'd0);
        check_eq({tag, "_hold"}, 64'(o_dbus_rdt), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic ibus_fetch(input logic [31:0] adr, input string tag, output logic [31:0] got);
        int          lat;
        logic [31:0] exp;
        exp = mem_m[int'(adr[MEM_AW+1:2])];
        i_ibus_adr = adr; i_ibus_cyc = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!o_ibus_ack && lat < 8) begin lat++; @(negedge clk); end
        check_eq({tag, "_lat"}, 64'(lat), 64'd1);
        got = o_ibus_rdt;
        check_eq({tag, "_rdt"}, 64'(got), 64'(exp));
        @(posedge clk); #1;
        i_ibus_cyc = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ack2"}, 64'(o_ibus_ack), 64'd0);
        check_eq({tag, "_hold"}, 64'(o_ibus_rdt), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic check_irq(input string tag);
        logic exp;
        @(negedge clk);
        exp = TMR_EN && (mtime_at(cnt - 1) >= cmp_m);
        check_eq(tag, 64'(o_timer_irq), 64'(exp));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] ram_adr(input int w);
        logic [31:0] a;
        a = $urandom;
        a[31] = 1'b0;
        a[MEM_AW+1:2] = MEM_AW'(w);
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int          n, dack, iack, consec, obs, exp_k, w, off;
        logic        pd, pi;
        logic [31:0] drdt, irdt;

        repeat (3) @(posedge clk); #1;
        i_rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("rst_iack", 64'(o_ibus_ack), 64'd0);
        check_eq("rst_dack", 64'(o_dbus_ack), 64'd0);
        check_eq("rst_irdt", 64'(o_ibus_rdt), 64'd0);
        check_eq("rst_drdt", 64'(o_dbus_rdt), 64'd0);
        check_eq("rst_irq",  64'(o_timer_irq), 64'd0);
        @(posedge clk); #1;

        // Basic write/read, byte enable and aliasing.
        dbus_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "w0", got);
        dbus_xfer(1'b0, 32'h10, 32'h0, 4'h0, "r0", got);
        check_eq("r0_val", 64'(got), 64'hDEAD_BEEF);
        dbus_xfer(1'b1, 32'h10, 32'h1122_3344, 4'hF, "w1", got);
        dbus_xfer(1'b1, 32'h10, 32'h0000_00AA, 4'h1, "wb", got);
        dbus_xfer(1'b0, 32'h10, 32'h0, 4'h0, "rb", got);
        check_eq("rb_val", 64'(got), 64'h1122_33AA);
        dbus_xfer(1'b0, 32'h10 + MEM_WORDS * 4, 32'h0, 4'h0, "ralias", got);
        check_eq("ralias_val", 64'(got), 64'h1122_33AA);
        ibus_fetch(TIMER_BASE | 32'h10, "ifetch_tb", got);
        dbus_xfer(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, "w2", got);

        // Simultaneous requests: dbus first, ibus three cycles later.
        n = cnt; dack = -1; iack = -1; consec = 0; pd = 1'b0; pi = 1'b0; drdt = 32'h0; irdt = 32'h0;
        i_dbus_adr = 32'h20; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_cyc = 1'b1;
        i_ibus_adr = 32'h10; i_ibus_cyc = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_dbus_ack && dack < 0) begin dack = cnt; drdt = o_dbus_rdt; end
            if (o_ibus_ack && iack < 0) begin iack = cnt; irdt = o_ibus_rdt; end
            if ((o_dbus_ack && pd) || (o_ibus_ack && pi)) consec++;
            pd = o_dbus_ack; pi = o_ibus_ack;
            @(posedge clk); #1;
            if (dack >= 0) i_dbus_cyc = 1'b0;
            if (iack >= 0) i_ibus_cyc = 1'b0;
        end
        check_eq("arb_dack_cyc", 64'(dack), 64'(n + 1));
        check_eq("arb_iack_cyc", 64'(iack), 64'(n + 4));
        check_eq("arb_consec", 64'(consec), 64'd0);
        check_eq("arb_drdt", 64'(drdt), 64'(mem_m[8]));
        check_eq("arb_irdt", 64'(irdt), 64'(mem_m[4]));

        // Timer interrupt rises one cycle after mtime reaches mtimecmp.
        do_reset();
        dbus_xfer(1'b1, TIMER_BASE | 32'h8, 32'd20, 4'hF, "cmp_lo", got);
        dbus_xfer(1'b1, TIMER_BASE | 32'hC, 32'h0, 4'hF, "cmp_hi", got);
        exp_k = TMR_EN ? (m_base_cyc + 21 - int'(m_base[31:0])) : -1;
        obs = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_timer_irq && obs < 0) obs = cnt;
        end
        @(posedge clk); #1;
        check_eq("irq_rise_cyc", 64'(obs), 64'(exp_k));
        check_irq("irq_level");
        dbus_xfer(1'b1, TIMER_BASE | 32'hC, 32'hFFFF_FFFF, 4'hF, "cmp_raise", got);
        check_irq("irq_clear");

        // 64-bit wrap of mtime.
        dbus_xfer(1'b1, TIMER_BASE | 32'h4, 32'hFFFF_FFFF, 4'hF, "mt_hi", got);
        dbus_xfer(1'b1, TIMER_BASE | 32'h0, 32'hFFFF_FFFF, 4'hF, "mt_lo", got);
        dbus_xfer(1'b0, TIMER_BASE | 32'h4, 32'h0, 4'h0, "wrap_hi", got);
        check_eq("wrap_hi_zero", 64'(got), 64'd0);
        dbus_xfer(1'b0, TIMER_BASE | 32'h0, 32'h0, 4'h0, "wrap_lo", got);
        check_irq("wrap_irq");

        // Randomized mix of RAM, fetch and timer traffic.
        for (int it = 0; it < 80; it++) begin
            w = int'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: dbus_xfer(1'b1, ram_adr(w), $urandom,
                                      valid_m[w] ? 4'($urandom) : 4'hF, "rnd_w", got);
                4, 5, 6: begin
                    if (valid_m[w]) dbus_xfer(1'b0, ram_adr(w), 32'h0, 4'h0, "rnd_r", got);
                    else dbus_xfer(1'b1, ram_adr(w), $urandom, 4'hF, "rnd_wf", got);
                end
                7, 8: begin
                    if (valid_m[w]) ibus_fetch($urandom & ~32'(MEM_WORDS * 4 - 1) | 32'(w * 4), "rnd_i", got);
                    else dbus_xfer(1'b1, ram_adr(w), $urandom, 4'hF, "rnd_wf", got);
                end
                default: begin
                    off = int'($urandom_range(0, 3));
                    dbus_xfer($urandom_range(0, 3) == 0, TIMER_BASE | 32'(off * 4) | 32'($urandom_range(0, 3)),
                              $urandom, 4'($urandom), "rnd_t", got);
                end
            endcase
            check_irq("rnd_irq");
        end

        // Reset during RESP of a read: ack drops, timer restarts, RAM is kept.
        i_dbus_adr = 32'h10; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_cyc = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_resp_ack", 64'(o_dbus_ack), 64'd1);
        @(posedge clk); #1;
        i_rst = 1'b0; i_dbus_cyc = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("mrst_ack", 64'(o_dbus_ack), 64'd0);
        check_eq("mrst_irq", 64'(o_timer_irq), 64'd0);
        check_eq("mrst_rdt", 64'(o_dbus_rdt), 64'd0);
        @(posedge clk); #1;
        dbus_xfer(1'b0, TIMER_BASE, 32'h0, 4'h0, "mrst_mtime", got);
        dbus_xfer(1'b0, TIMER_BASE | 32'hC, 32'h0, 4'h0, "mrst_cmp", got);
        dbus_xfer(1'b0, 32'h20, 32'h0, 4'h0, "mrst_ram", got);
        check_irq("mrst_irq2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
